// File: rtl/wasm_run_ctrl_pkg.sv
// Shared types for the WASM run controller: work-state encoding and small helpers.
package wasm_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } work_state_e;

    // Line-memory readback is only safe while the core is not mutating it.
    function automatic logic readback_allowed(work_state_e s);
        return (s == ST_PAUSE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/wasm_dbg_shifter.sv
// Debug probe snapshot: captures the probe bus on request and streams it out MSB first.
module wasm_dbg_shifter
    import wasm_run_ctrl_pkg::*;
#(
    parameter int PROBE_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req,
    input  logic [PROBE_W-1:0] i_probe,
    output logic               o_data,
    output logic               o_valid
);

    localparam int CNT_W = $clog2(PROBE_W + 1);

    logic [PROBE_W-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy;

    assign busy = (cnt_q != '0);

    // A request arriving while a snapshot is still streaming is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (busy) begin
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - 1'b1;
        end else if (i_req) begin
            shreg_q <= i_probe;
            cnt_q   <= CNT_W'(PROBE_W);
        end
    end

    assign o_valid = busy;
    assign o_data  = busy & shreg_q[PROBE_W-1];

endmodule

// File: rtl/wasm_run_ctrl.sv
// Run controller for the WASM core: work-state FSM, instruction load handshake,
// debug pause/step, sticky errors, pipelined line-memory readback and probe snapshot.
module wasm_run_ctrl
    import wasm_run_ctrl_pkg::*;
#(
    parameter int IADDR_W  = 8,
    parameter int IDATA_W  = 64,
    parameter int LADDR_W  = 8,
    parameter int LDATA_W  = 32,
    parameter int LMEM_LAT = 1,
    parameter int ERR_W    = 3,
    parameter int PROBE_W  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic [1:0]         o_work_state,
    output logic [ERR_W-1:0]   o_ERROR,
    output logic               o_instr_mem_wr_rdy,
    input  logic               i_instr_mem_wr_vld,
    input  logic [IADDR_W-1:0] i_instr_mem_wr_addr,
    input  logic [IDATA_W-1:0] i_instr_mem_wr_data,
    input  logic               i_instr_mem_write_finish,
    output logic               o_imem_we,
    output logic [IADDR_W-1:0] o_imem_addr,
    output logic [IDATA_W-1:0] o_imem_wdata,
    output logic               o_core_run,
    input  logic               i_core_finish,
    input  logic [ERR_W-1:0]   i_core_error,
    input  logic               i_debug_ena,
    input  logic               i_debug_step,
    input  logic               i_restart,
    input  logic               i_line_mem_rd_rdy,
    input  logic [LADDR_W-1:0] i_line_mem_rd_addr,
    output logic               o_line_mem_rd_vld,
    output logic [LDATA_W-1:0] o_line_mem_rd_data,
    output logic               o_lmem_re,
    output logic [LADDR_W-1:0] o_lmem_addr,
    input  logic [LDATA_W-1:0] i_lmem_rdata,
    input  logic               i_debug_req,
    input  logic [PROBE_W-1:0] i_probe,
    output logic               o_debug_data,
    output logic               o_debug_valid
);

    work_state_e        state_q, state_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IADDR_W:0]   words_q, words_d;
    logic               imem_we_q;
    logic [IADDR_W-1:0] imem_addr_q;
    logic [IDATA_W-1:0] imem_wdata_q;
    logic               step_prev_q;

    logic wr_rdy;
    logic wr_fire;
    logic step_fire;
    logic core_run;

    assign wr_rdy    = (state_q == ST_LOAD);
    assign wr_fire   = wr_rdy & i_instr_mem_wr_vld;
    // Edge-detect the step so a held step line still yields one run cycle.
    assign step_fire = (state_q == ST_PAUSE) & i_debug_step & ~step_prev_q;
    assign core_run  = (state_q == ST_RUN) | step_fire;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        words_d = words_q;

        if (wr_fire && !(&words_q)) begin
            words_d = words_q + 1'b1;
        end

        case (state_q)
            ST_LOAD: begin
                if (i_instr_mem_write_finish) begin
                    // A write landing with finish still counts as a loaded word.
                    if ((words_q == '0) && !wr_fire) begin
                        err_d[ERR_W-1] = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (core_run && (i_core_error != '0)) begin
                    err_d   = err_q | i_core_error;
                    state_d = ST_DONE;
                end else if (core_run && i_core_finish) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = i_debug_ena ? ST_PAUSE : ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_restart) begin
                    state_d = ST_LOAD;
                    err_d   = '0;
                    words_d = '0;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_LOAD;
            err_q        <= '0;
            words_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            step_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            words_q     <= words_d;
            imem_we_q   <= wr_fire;
            step_prev_q <= i_debug_step;
            if (wr_fire) begin
                imem_addr_q  <= i_instr_mem_wr_addr;
                imem_wdata_q <= i_instr_mem_wr_data;
            end
        end
    end

    assign o_work_state       = state_q;
    assign o_ERROR            = err_q;
    assign o_instr_mem_wr_rdy = wr_rdy;
    assign o_imem_we          = imem_we_q;
    assign o_imem_addr        = imem_addr_q;
    assign o_imem_wdata       = imem_wdata_q;
    assign o_core_run         = core_run;

    // Readback: bit k of the pipe is an accepted request delayed k+1 cycles;
    // memory data is valid at stage LMEM_LAT-1 and re-registered for the host.
    logic               rd_accept;
    logic [LMEM_LAT:0]  rd_pipe_q;
    logic [LDATA_W-1:0] rd_data_q;

    assign rd_accept   = i_line_mem_rd_rdy & readback_allowed(state_q);
    assign o_lmem_re   = rd_accept;
    assign o_lmem_addr = rd_accept ? i_line_mem_rd_addr : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pipe_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_pipe_q <= {rd_pipe_q[LMEM_LAT-1:0], rd_accept};
            if (rd_pipe_q[LMEM_LAT-1]) begin
                rd_data_q <= i_lmem_rdata;
            end
        end
    end

    assign o_line_mem_rd_vld  = rd_pipe_q[LMEM_LAT];
    assign o_line_mem_rd_data = rd_data_q;

    wasm_dbg_shifter #(
        .PROBE_W (PROBE_W)
    ) u_dbg_shifter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_debug_req),
        .i_probe (i_probe),
        .o_data  (o_debug_data),
        .o_valid (o_debug_valid)
    );

endmodule
